// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, state encoding and fixed operand addresses
// for the system-side UART command controller.
package sys_ctrl_pkg;

  localparam logic [7:0] RF_WR_CMD   = 8'hAA;
  localparam logic [7:0] RF_RD_CMD   = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  localparam logic [3:0] OPA_ADDR = 4'd0;
  localparam logic [3:0] OPB_ADDR = 4'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OPA,
    ST_OPB,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_e;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// Command frame parser: turns RX bytes into register-file/ALU
// strobes and streams read/ALU results to the TX FIFO.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    alu_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  input  logic                    tx_full,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    is_alu_q, is_alu_d;

  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic                    alu_en_q, alu_en_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  logic is_wr, is_rd, is_op, is_nop;
  logic cnt_done;

  assign is_wr  = rx_data == DATA_WIDTH'(RF_WR_CMD);
  assign is_rd  = rx_data == DATA_WIDTH'(RF_RD_CMD);
  assign is_op  = rx_data == DATA_WIDTH'(ALU_OP_CMD);
  assign is_nop = rx_data == DATA_WIDTH'(ALU_NOP_CMD);

  assign cnt_done = cnt_q == TW'(TIMEOUT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    res_d        = res_q;
    is_alu_d     = is_alu_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_fun_d    = alu_fun_q;
    alu_en_d     = 1'b0;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            is_wr:   state_d = ST_WR_ADDR;
            is_rd:   state_d = ST_RD_ADDR;
            is_op:   state_d = ST_OPA;
            is_nop:  state_d = ST_ALU_FUN;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_q;
          rf_wr_data_d = rx_data;
          state_d      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_valid) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
          cnt_d      = '0;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // valid strobe takes priority over an expiring counter
        if (rf_rd_valid) begin
          res_d    = {{DATA_WIDTH{1'b0}}, rf_rd_data};
          is_alu_d = 1'b0;
          state_d  = ST_TX_LO;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OPA: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_d = rx_data;
          state_d      = ST_OPB;
        end
      end
      ST_OPB: begin
        if (rx_valid) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_d = rx_data;
          state_d      = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (rx_valid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[FUN_WIDTH-1:0];
          cnt_d     = '0;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (alu_out_valid) begin
          res_d    = alu_out;
          is_alu_d = 1'b1;
          state_d  = ST_TX_LO;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TX_LO: begin
        if (!tx_full) begin
          tx_valid_d = 1'b1;
          tx_data_d  = res_q[DATA_WIDTH-1:0];
          state_d    = is_alu_q ? ST_TX_HI : ST_IDLE;
        end
      end
      ST_TX_HI: begin
        if (!tx_full) begin
          tx_valid_d = 1'b1;
          tx_data_d  = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      res_q        <= '0;
      is_alu_q     <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      res_q        <= res_d;
      is_alu_q     <= is_alu_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_fun_q    <= alu_fun_d;
      alu_en_q     <= alu_en_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign alu_fun    = alu_fun_q;
  assign alu_en     = alu_en_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Random and directed frames against an expected-strobe queue
// built from the command rules.
module tb_sys_cmd_ctrl;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_valid = 1'b0;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        tx_full = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;

  sys_cmd_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_full(tx_full), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // kind: 0 rf write, 1 rf read, 2 alu start, 3 tx byte
  typedef struct {
    int kind;
    int a;
    int d;
  } ev_t;

  ev_t expq[$];
  int  errs = 0;
  int  checks = 0;
  bit  mon_on = 0;
  bit  rnd_full = 0;
  bit  rnd_gap = 0;
  logic full_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) full_s = tx_full;

  initial forever begin
    @(negedge clk);
    if (mon_on && rst) begin
      int n;
      int kind;
      n = int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) + int'(tx_valid);
      if (n != 0) begin
        chk("one_strobe", n, 1);
        kind = tx_valid ? 3 : alu_en ? 2 : rf_rd_en ? 1 : 0;
        if (tx_valid) chk("tx_while_full", full_s, 0);
        if (expq.size() == 0) begin
          chk("spurious_strobe", n, 0);
        end else begin
          ev_t e;
          e = expq.pop_front();
          chk("kind", kind, e.kind);
          case (kind)
            0: begin
              chk("wr_addr", rf_addr, e.a);
              chk("wr_data", rf_wr_data, e.d);
            end
            1: chk("rd_addr", rf_addr, e.a);
            2: chk("alu_fun", alu_fun, e.a);
            default: chk("tx_data", tx_data, e.d);
          endcase
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd_full) tx_full = ($urandom_range(0, 3) == 0);
  end

  task automatic send(input logic [7:0] b);
    if (rnd_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if ((which == 1) ? rf_rd_en : alu_en) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && expq.size() != 0; i++) @(negedge clk);
    chk("drain", expq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] with_junk(input logic [3:0] v);
    logic [3:0] hi;
    hi = 4'($urandom);
    return {hi, v};
  endfunction

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
    expq.push_back('{0, int'(a), int'(d)});
    send(8'hAA);
    send(with_junk(a));
    send(d);
    drain();
  endtask

  task automatic do_rd(input logic [3:0] a, input logic [7:0] d,
                       input int lat);
    bit ok;
    expq.push_back('{1, int'(a), 0});
    expq.push_back('{3, 0, int'(d)});
    send(8'hBB);
    send(with_junk(a));
    wait_sig(1, ok);
    chk("rd_en_seen", ok, 1);
    if (ok) begin
      repeat (lat) @(negedge clk);
      rf_rd_data  = d;
      rf_rd_valid = 1'b1;
      @(negedge clk);
      rf_rd_valid = 1'b0;
    end
    drain();
  endtask

  task automatic do_alu(input bit two, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] f,
                        input logic [15:0] r, input int lat,
                        input int stall);
    bit ok;
    if (two) begin
      expq.push_back('{0, 0, int'(a)});
      expq.push_back('{0, 1, int'(b)});
    end
    expq.push_back('{2, int'(f), 0});
    expq.push_back('{3, 0, int'(r[7:0])});
    expq.push_back('{3, 0, int'(r[15:8])});
    send(two ? 8'hCC : 8'hDD);
    if (two) begin
      send(a);
      send(b);
    end
    send(with_junk(f));
    wait_sig(2, ok);
    chk("alu_en_seen", ok, 1);
    if (ok) begin
      if (stall > 0) tx_full = 1'b1;
      repeat (lat) @(negedge clk);
      alu_out       = r;
      alu_out_valid = 1'b1;
      @(negedge clk);
      alu_out_valid = 1'b0;
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        chk("held_while_full", expq.size(), 2);
        tx_full = 1'b0;
      end
    end
    drain();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [7:0] g;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_rd_en", rf_rd_en, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_alu_fun", alu_fun, 0);
    chk("rst_tx_data", tx_data, 0);
    rst    = 1'b1;
    mon_on = 1;
    @(negedge clk);

    do_wr(4'h5, 8'h3C);
    do_rd(4'h5, 8'h3C, 3);
    do_alu(1, 8'h0A, 8'h03, 4'h0, 16'h000D, 2, 0);
    do_alu(0, 8'h00, 8'h00, 4'h2, 16'hBEEF, 1, 10);

    // read that never completes; frame sent mid-wait is dropped
    expq.push_back('{1, 1, 0});
    send(8'hBB);
    send(8'h01);
    wait_sig(1, ok);
    chk("to_rd_en_seen", ok, 1);
    repeat (100) @(negedge clk);
    send(8'hAA);
    send(8'h02);
    send(8'h11);
    repeat (TMO + 10) @(negedge clk);
    chk("to_queue", expq.size(), 0);
    do_wr(4'h2, 8'h11);

    // mid-frame reset then stray bytes
    send(8'hAA);
    send(8'h07);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", {rf_wr_en, rf_rd_en, alu_en, tx_valid,
                         rf_addr, alu_fun, rf_wr_data, tx_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    send(8'h3C);
    send(8'h55);
    repeat (4) @(negedge clk);
    do_wr(4'h3, 8'h5A);

    rnd_gap  = 1;
    rnd_full = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do g = 8'($urandom);
        while (g == 8'hAA || g == 8'hBB || g == 8'hCC || g == 8'hDD);
        send(g);
      end
      case ($urandom_range(0, 3))
        0: do_wr(4'($urandom), 8'($urandom));
        1: do_rd(4'($urandom), 8'($urandom), $urandom_range(0, 6));
        2: do_alu(1, 8'($urandom), 8'($urandom), 4'($urandom),
                  16'($urandom), $urandom_range(0, 6), 0);
        default: do_alu(0, 8'h00, 8'h00, 4'($urandom),
                        16'($urandom), $urandom_range(0, 6), 0);
      endcase
    end
    rnd_full = 0;
    tx_full  = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("final_queue", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
